fb_mem_arbiter: RTL and testbench

//   Shares the single-port data/frame-buffer RAM between the pipeline MEM stage
//   (LOAD/STR/STR_ONE/PIC traffic) and the camera pixel writer. Buffers camera

---
 rtl/fb_mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_fb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter: shares the single-port data/frame-buffer RAM between the
// pipeline MEM stage and the camera pixel writer. Camera pixels are queued in
// a small FIFO of {address, pixel} entries; one RAM access is granted per
// cycle and the pipeline is stalled while the camera drains or a load waits.
module fb_mem_arbiter #(
    parameter int AW         = 18,
    parameter int DW         = 32,
    parameter int PW         = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int HIGH_WATER = 3,
    parameter int FB_BASE    = 'h10000,
    parameter int FRAME_PIX  = 'h4B00
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemReadM,
    input  logic          MemWriteM,
    input  logic [AW-1:0] ALUOutM,
    input  logic [DW-1:0] WriteDataM,
    output logic [DW-1:0] ReadDataM,
    output logic          StallM,
    input  logic          cam_valid,
    input  logic [PW-1:0] cam_pixel,
    input  logic          cam_frame_start,
    output logic          cam_overflow,
    output logic          frame_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;

    localparam logic [AW-1:0] BASE_ADDR = AW'(FB_BASE);
    localparam logic [AW-1:0] LAST_ADDR = AW'(FB_BASE + FRAME_PIX - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] HIGH_C    = CW'(HIGH_WATER);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t          state_reg, state_next;

    // camera FIFO storage and bookkeeping
    logic [AW-1:0]   fifo_addr_mem [FIFO_DEPTH];
    logic [PW-1:0]   fifo_pix_mem  [FIFO_DEPTH];
    logic [PTRW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   streak_reg;   // consecutive camera grants over a waiting CPU
    logic [AW-1:0]   pix_addr_reg;
    logic            overflow_reg;
    logic            frame_done_reg;
    logic [DW-1:0]   read_data_reg;

    logic            cpu_pend, fifo_empty, fifo_full, starve, cam_win;
    logic            pop, push_ok;
    logic [AW-1:0]   head_addr, entry_addr, entry_next;
    logic [PW-1:0]   head_pix;

    logic            en_c, we_c, stall_c;
    logic [AW-1:0]   addr_c;
    logic [DW-1:0]   wdata_c;

    assign cpu_pend   = MemReadM | MemWriteM;
    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == DEPTH_C);
    assign head_addr  = fifo_addr_mem[rd_ptr_reg];
    assign head_pix   = fifo_pix_mem[rd_ptr_reg];

    // Once the camera has taken FIFO_DEPTH grants in a row over a waiting
    // request, the CPU gets the next slot so it cannot starve.
    assign starve  = cpu_pend & (streak_reg == DEPTH_C);
    assign cam_win = ~fifo_empty & ((count_reg >= HIGH_C) | ~cpu_pend) & ~starve;

    // A full FIFO still accepts a pixel when its head leaves in the same cycle.
    assign push_ok    = cam_valid & (~fifo_full | pop);
    assign entry_addr = cam_frame_start ? BASE_ADDR : pix_addr_reg;
    assign entry_next = (entry_addr == LAST_ADDR) ? BASE_ADDR : entry_addr + AW'(1);

    // Grant selection, next state and RAM port drive for the current cycle
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        en_c       = 1'b0;
        we_c       = 1'b0;
        addr_c     = '0;
        wdata_c    = '0;
        stall_c    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cam_win) begin
                    pop     = 1'b1;
                    en_c    = 1'b1;
                    we_c    = 1'b1;
                    addr_c  = head_addr;
                    wdata_c = DW'(head_pix);
                    stall_c = cpu_pend;
                end else if (MemReadM) begin
                    en_c       = 1'b1;
                    addr_c     = ALUOutM;
                    stall_c    = 1'b1;
                    state_next = RD_WAIT;
                end else if (MemWriteM) begin
                    en_c    = 1'b1;
                    we_c    = 1'b1;
                    addr_c  = ALUOutM;
                    wdata_c = WriteDataM;
                end
            end
            RD_WAIT: begin
                // read data returns this cycle; the port itself is free for the camera
                state_next = IDLE;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    en_c    = 1'b1;
                    we_c    = 1'b1;
                    addr_c  = head_addr;
                    wdata_c = DW'(head_pix);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // RAM port and stall are forced idle for as long as reset is held
    assign mem_en    = en_c & ~reset;
    assign mem_we    = we_c & ~reset;
    assign mem_addr  = reset ? '0 : addr_c;
    assign mem_wdata = reset ? '0 : wdata_c;
    assign StallM    = stall_c & ~reset;

    assign ReadDataM    = read_data_reg;
    assign cam_overflow = overflow_reg;
    assign frame_done   = frame_done_reg;

    // FIFO payload; pointers are reset, contents need not be
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_addr_mem[wr_ptr_reg] <= entry_addr;
            fifo_pix_mem[wr_ptr_reg]  <= cam_pixel;
        end
    end

    // Control state: FSM, FIFO pointers, pixel address, flags and load data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            streak_reg     <= '0;
            pix_addr_reg   <= BASE_ADDR;
            overflow_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            read_data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (push_ok) begin
                wr_ptr_reg   <= wr_ptr_reg + PTRW'(1);
                pix_addr_reg <= entry_next;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTRW'(1);
            end
            count_reg <= count_reg + CW'(push_ok) - CW'(pop);

            if (push_ok && cam_frame_start) begin
                overflow_reg <= 1'b0;
            end else if (cam_valid && !push_ok) begin
                overflow_reg <= 1'b1;
            end

            frame_done_reg <= pop & (head_addr == LAST_ADDR);

            if (state_reg == IDLE && cpu_pend && pop) begin
                streak_reg <= streak_reg + CW'(1);
            end else begin
                streak_reg <= '0;
            end

            if (state_reg == RD_WAIT) begin
                read_data_reg <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter: CPU-only access, camera-only capture,
// contention, FIFO overflow, frame wrap with a short frame, and reset mid-load.
module tb_fb_mem_arbiter;

    localparam int AW = 18;
    localparam int DW = 32;
    localparam int PW = 8;
    localparam logic [AW-1:0] FB = 18'h10000;

    logic          clk = 1'b0;
    logic          reset;
    logic          MemReadM, MemWriteM;
    logic [AW-1:0] ALUOutM;
    logic [DW-1:0] WriteDataM;
    logic [DW-1:0] ReadDataM;
    logic          StallM;
    logic          cam_valid;
    logic [PW-1:0] cam_pixel;
    logic          cam_frame_start;
    logic          cam_overflow, frame_done;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int errs   = 0;
    int checks = 0;
    int cam_writes = 0;
    int fd_count   = 0;
    bit drop_seen  = 0;
    int cw0, fd0;

    logic [DW-1:0] ram [logic [AW-1:0]];

    fb_mem_arbiter #(
        .AW(AW), .DW(DW), .PW(PW), .FIFO_DEPTH(4), .HIGH_WATER(3),
        .FB_BASE('h10000), .FRAME_PIX(8)
    ) dut (
        .clk(clk), .reset(reset),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .StallM(StallM),
        .cam_valid(cam_valid), .cam_pixel(cam_pixel),
        .cam_frame_start(cam_frame_start),
        .cam_overflow(cam_overflow), .frame_done(frame_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ram_rd(logic [AW-1:0] a);
        return ram.exists(a) ? ram[a] : '0;
    endfunction

    // RAM model with one-cycle read latency, plus write and frame_done monitors
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= ram_rd(mem_addr);
        if (mem_en && mem_we) begin
            ram[mem_addr] = mem_wdata;
            if (mem_addr >= FB) begin
                cam_writes++;
                if (mem_wdata == 32'h2C) drop_seen = 1;
            end
        end
        if (frame_done) fd_count++;
    end

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemReadM = 0; MemWriteM = 0; ALUOutM = '0; WriteDataM = '0;
        cam_valid = 0; cam_pixel = '0; cam_frame_start = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        idle_inputs();
        tick();
        tick();
        reset = 0;
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        tick();
        tick();
        check_eq("rst_stall",  StallM,       0);
        check_eq("rst_en",     mem_en,       0);
        check_eq("rst_rdata",  ReadDataM,    0);
        check_eq("rst_ovf",    cam_overflow, 0);
        check_eq("rst_fdone",  frame_done,   0);
        reset = 0;

        // 1: CPU only - store then load the same word
        MemWriteM = 1; ALUOutM = 18'h40; WriteDataM = 32'hDEADBEEF;
        @(negedge clk);
        check_eq("t1_st_stall", StallM, 0);
        check_eq("t1_st_enwe", {mem_en, mem_we}, 2'b11);
        tick();
        MemWriteM = 0; MemReadM = 1;
        @(negedge clk);
        check_eq("t1_ld_stall", StallM, 1);
        check_eq("t1_ld_enwe", {mem_en, mem_we}, 2'b10);
        check_eq("t1_ld_addr", mem_addr, 18'h40);
        tick();
        @(negedge clk);
        check_eq("t1_rw_stall", StallM, 0);
        check_eq("t1_rw_en", mem_en, 0);
        tick();
        MemReadM = 0;
        check_eq("t1_rdata", ReadDataM, 32'hDEADBEEF);

        // 2: camera only, five pixels starting a frame
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cam_valid = 1; cam_pixel = 8'(8'h11 + i); cam_frame_start = (i == 0);
            @(negedge clk);
            check_eq($sformatf("t2_stall%0d", i), StallM, 0);
            tick();
        end
        idle_inputs();
        repeat (3) tick();
        for (int i = 0; i < 5; i++)
            check_eq($sformatf("t2_ram%0d", i), ram_rd(FB + AW'(i)), 32'(8'h11 + i));

        // 3: contention - FIFO at high water while a store waits
        do_reset();
        for (int i = 0; i < 3; i++) begin
            MemWriteM = 1; ALUOutM = 18'(18'h100 + i); WriteDataM = 32'(32'hA0 + i);
            cam_valid = 1; cam_pixel = 8'(8'h31 + i); cam_frame_start = (i == 0);
            tick();
        end
        cam_valid = 0; cam_frame_start = 0;
        ALUOutM = 18'h200; WriteDataM = 32'hCAFEF00D;
        @(negedge clk);
        check_eq("t3_cam_stall", StallM, 1);
        check_eq("t3_cam_addr", mem_addr, FB);
        tick();
        @(negedge clk);
        check_eq("t3_st_stall", StallM, 0);
        check_eq("t3_st_addr", mem_addr, 18'h200);
        tick();
        idle_inputs();
        repeat (4) tick();
        check_eq("t3_ram_st", ram_rd(18'h200), 32'hCAFEF00D);
        check_eq("t3_ram_st0", ram_rd(18'h100), 32'hA0);
        check_eq("t3_ram_px2", ram_rd(FB + 18'd2), 32'h33);

        // 4: overflow under a continuous store stream; pixel 12 is dropped
        do_reset();
        cw0 = cam_writes; fd0 = fd_count;
        MemWriteM = 1; ALUOutM = 18'h300; WriteDataM = 32'h12345678;
        for (int i = 0; i < 13; i++) begin
            cam_valid = 1; cam_pixel = 8'(8'h20 + i); cam_frame_start = (i == 0);
            if (i == 3) begin
                @(negedge clk);
                check_eq("t4_cam_stall", StallM, 1);
            end
            if (i == 12) begin
                check_eq("t4_ovf_before", cam_overflow, 0);
                @(negedge clk);
                check_eq("t4_cpu_stall", StallM, 0);
                check_eq("t4_cpu_addr", mem_addr, 18'h300);
            end
            tick();
        end
        check_eq("t4_ovf_set", cam_overflow, 1);
        idle_inputs();
        repeat (6) tick();
        check_eq("t4_ram0", ram_rd(FB), 32'h28);
        check_eq("t4_ram3", ram_rd(FB + 18'd3), 32'h2B);
        check_eq("t4_ram4", ram_rd(FB + 18'd4), 32'h24);
        check_eq("t4_ram7", ram_rd(FB + 18'd7), 32'h27);
        check_eq("t4_nwrites", 32'(cam_writes - cw0), 12);
        check_eq("t4_no_drop_wr", 32'(drop_seen), 0);
        check_eq("t4_fdone", 32'(fd_count - fd0), 1);
        cam_valid = 1; cam_pixel = 8'h55; cam_frame_start = 1;
        tick();
        idle_inputs();
        check_eq("t4_ovf_clr", cam_overflow, 0);
        repeat (2) tick();

        // 5: frame wrap with an 8-pixel frame
        do_reset();
        fd0 = fd_count;
        for (int k = 0; k < 12; k++) begin
            cam_valid = (k < 9); cam_pixel = 8'(8'h60 + k); cam_frame_start = (k == 0);
            @(negedge clk);
            check_eq($sformatf("t5_fdone%0d", k), frame_done, (k == 9));
            tick();
        end
        idle_inputs();
        check_eq("t5_fd_count", 32'(fd_count - fd0), 1);
        check_eq("t5_ram0", ram_rd(FB), 32'h68);
        check_eq("t5_ram1", ram_rd(FB + 18'd1), 32'h61);
        check_eq("t5_ram7", ram_rd(FB + 18'd7), 32'h67);

        // 6: reset asserted during RD_WAIT with two pixels queued
        do_reset();
        for (int i = 0; i < 2; i++) begin
            MemWriteM = 1; ALUOutM = 18'h400; WriteDataM = 32'(i + 1);
            cam_valid = 1; cam_pixel = 8'(8'h90 + i); cam_frame_start = 0;
            tick();
        end
        MemWriteM = 0; MemReadM = 1; ALUOutM = 18'h40; cam_valid = 0;
        @(negedge clk);
        check_eq("t6_ld_stall", StallM, 1);
        tick();
        reset = 1;
        idle_inputs();
        #1;
        check_eq("t6_rst_stall", StallM, 0);
        check_eq("t6_rst_en", {mem_en, mem_we}, 0);
        check_eq("t6_rst_addr", mem_addr, 0);
        check_eq("t6_rst_wdata", mem_wdata, 0);
        check_eq("t6_rst_rdata", ReadDataM, 0);
        tick();
        tick();
        reset = 0;
        cw0 = cam_writes;
        repeat (5) tick();
        check_eq("t6_no_wr", 32'(cam_writes - cw0), 0);
        cam_valid = 1; cam_pixel = 8'h77;
        tick();
        idle_inputs();
        repeat (2) tick();
        check_eq("t6_one_wr", 32'(cam_writes - cw0), 1);
        check_eq("t6_ram_base", ram_rd(FB), 32'h77);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
